// File: rtl/rca_word_seq.sv
// rtl/rca_word_seq.sv - multi-precision add sequencer around one shared SIZE-bit ripple-carry adder
module rca_word_seq #(
    parameter int SIZE  = 8,
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORDS*SIZE-1:0] in_a,
    input  logic [WORDS*SIZE-1:0] in_b,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORDS*SIZE-1:0] out_sum,
    output logic                  out_cout,
    output logic                  busy,
    output logic [SIZE-1:0]       rca_a,
    output logic [SIZE-1:0]       rca_b,
    output logic                  rca_cin,
    input  logic [SIZE-1:0]       rca_s,
    input  logic                  rca_cout
);

    localparam int W  = WORDS * SIZE;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          carry;
    logic [IW-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            sum_reg <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        carry <= in_cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    // Carry register chains the word adds across cycles, LSW first.
                    sum_reg[idx*SIZE +: SIZE] <= rca_s;
                    carry                     <= rca_cout;
                    if (idx != LAST_IDX) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        rca_a     = '0;
        rca_b     = '0;
        rca_cin   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                rca_a   = a_reg[idx*SIZE +: SIZE];
                rca_b   = b_reg[idx*SIZE +: SIZE];
                rca_cin = carry;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = sum_reg;
                out_cout  = carry;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rca_word_seq.sv
// tb/tb_rca_word_seq.sv - scoreboard bench for rca_word_seq with a behavioural shared adder
module tb_rca_word_seq;

    localparam int SIZE  = 8;
    localparam int WORDS = 4;
    localparam int W     = SIZE * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;
    logic [SIZE-1:0] rca_a;
    logic [SIZE-1:0] rca_b;
    logic            rca_cin;
    logic [SIZE-1:0] rca_s;
    logic            rca_cout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nacc   = 0;
    int nres   = 0;
    int hs_cyc = 0;
    int gap    = 0;
    logic [W:0] sb[$];

    rca_word_seq #(.SIZE(SIZE), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy),
        .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
        .rca_s(rca_s), .rca_cout(rca_cout)
    );

    assign {rca_cout, rca_s} = {1'b0, rca_a} + {1'b0, rca_b} + {{SIZE{1'b0}}, rca_cin};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshakes are sampled mid-cycle, so what is seen here is what the next rising edge commits.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            sb.push_back({1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin});
            gap = cyc - hs_cyc;
            nacc++;
        end
        if (!rst && out_valid && out_ready) begin
            hs_cyc = cyc;
            nres++;
            if (sb.size() == 0) begin
                check("unexpected_result", {out_cout, out_sum}, 0);
            end else begin
                check("result", {out_cout, out_sum}, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int n;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("in_ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_watch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [SIZE:0] t;
        logic c;
        c = cin;
        for (int i = 0; i < WORDS; i++) begin
            check("run_rca_a", rca_a, a[i*SIZE +: SIZE]);
            check("run_rca_b", rca_b, b[i*SIZE +: SIZE]);
            check("run_rca_cin", rca_cin, c);
            check("run_busy", busy, 1);
            check("run_in_ready", in_ready, 0);
            check("run_out_valid", out_valid, 0);
            t = {1'b0, a[i*SIZE +: SIZE]} + {1'b0, b[i*SIZE +: SIZE]} + {{SIZE{1'b0}}, c};
            c = t[SIZE];
            tick();
        end
        check("latency_out_valid", out_valid, 1);
        check("done_rca_a", rca_a, 0);
    endtask

    task automatic collect();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("out_valid_timeout", 0, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [W:0] exp;
        int acc0;
        int res0;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_cout", out_cout, 0);
        check("rst_rca", {rca_a, rca_b, rca_cin}, 0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", in_ready, 1);

        // Simple word-boundary carry.
        start(32'h0000_00FF, 32'h0000_0001, 1'b0);
        run_watch(32'h0000_00FF, 32'h0000_0001, 1'b0);
        check("t1_sum", out_sum, 32'h0000_0100);
        collect();

        // Carry-in ripples through every word.
        start(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        run_watch(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        check("t2_cout", out_cout, 1);
        collect();

        start(32'h7F7F_7F7F, 32'h0101_0101, 1'b0);
        run_watch(32'h7F7F_7F7F, 32'h0101_0101, 1'b0);
        check("t3_sum", out_sum, 32'h8080_8080);
        collect();

        // Backpressure in DONE.
        exp = {1'b0, 32'h1234_5678} + {1'b0, 32'h8765_4321} + 33'd1;
        start(32'h1234_5678, 32'h8765_4321, 1'b1);
        run_watch(32'h1234_5678, 32'h8765_4321, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_sum", {out_cout, out_sum}, exp);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        collect();

        // Abort mid-RUN at idx 2.
        start(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        tick();
        tick();
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        if (sb.size() > 0) void'(sb.pop_back());
        start(32'd5, 32'd10, 1'b0);
        run_watch(32'd5, 32'd10, 1'b0);
        check("t5_sum", out_sum, 32'd15);
        collect();

        // Back-to-back with in_valid held and out_ready tied high.
        acc0 = nacc;
        res0 = nres;
        out_ready = 1'b1;
        in_a = 32'hDEAD_BEEF; in_b = 32'h2152_4111; in_cin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (nacc == acc0 + 1) begin
                in_a = 32'h0102_0304; in_b = 32'hFFFF_FFFF; in_cin = 1'b1;
            end
            if (nacc >= acc0 + 2) in_valid = 1'b0;
            if (nres >= res0 + 2) break;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", nres - res0, 2);
        check("b2b_accept_gap", gap, 1);

        tick();
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
